// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter with a transmit FIFO.
//
// A store to BASE_ADDR queues WriteData[7:0]. A load from BASE_ADDR+4
// returns STATUS, which is driven combinationally on ReadData in the same
// cycle. Each byte goes out as 8N1: one start bit, eight data bits sent
// LSB first, and one stop bit. When UART_TX_PARITY_EN is defined, an even
// parity bit is inserted between the data bits and the stop bit.
//
// STATUS layout:
//   bit0 FULL, bit1 EMPTY, bit2 TxBusy, bit3 OVERRUN (sticky),
//   bits[14:8] FIFO count, all other bits 0.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   Address    byte address from the MEM stage
//   WriteData  store data; only bits [7:0] are used
//   MemWrite   store strobe
//   MemRead    load strobe
//   ReadData   combinational load data (STATUS or zero)
//   TxSerial   registered serial output, idles high
//   TxBusy     high while a frame is on the line or the FIFO holds data
//
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit).
//
// FSM states:
//   state    | meaning
//   S_IDLE   | line high, waiting for the FIFO to become non-empty
//   S_START  | driving the start bit (0)
//   S_DATA   | driving data bit bit_q, LSB first
//   S_PARITY | driving the even-parity bit (UART_TX_PARITY_EN only)
//   S_STOP   | driving the stop bit (1); pops the next byte if one is queued

module uart_tx_mmio #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0040
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        TxSerial,
  output logic        TxBusy
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;

  state_t        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic          wr_sel, rd_status;
  logic          fifo_empty, fifo_full;
  logic          baud_tc;
  logic          pop, push, overrun_evt;
  logic [7:0]    head;
  logic [6:0]    count_ext;
  logic          unused_wdata;

  // The upper store bits carry no meaning for this register.
  assign unused_wdata = ^WriteData[31:8];

  always_comb begin
    wr_sel     = MemWrite && (Address == BASE_ADDR);
    rd_status  = MemRead && (Address == STATUS_ADDR);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_CNT);
    baud_tc    = (baud_q == 16'd0);
    head       = fifo_mem[rd_ptr_q];
    // The FSM pops from IDLE, or on the last cycle of STOP so that frames
    // follow each other without an idle gap.
    pop        = !fifo_empty &&
                 ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_tc));
    // A push into a full FIFO is still accepted when a pop frees a slot on
    // the same edge.
    push        = wr_sel && (!fifo_full || pop);
    overrun_evt = wr_sel && !push;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // A new overrun on the edge that ends a STATUS read wins over the clear.
    if (overrun_evt)    overrun_d = 1'b1;
    else if (rd_status) overrun_d = 1'b0;
    else                overrun_d = overrun_q;
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d  = S_START;
          shift_d  = head;
          baud_d   = BAUD_RELOAD;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
        end
      end
      S_START: begin
        if (baud_tc) begin
          state_d = S_DATA;
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tc) begin
          state_d = S_STOP;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_tc) begin
          if (pop) begin
            state_d  = S_START;
            shift_d  = head;
            baud_d   = BAUD_RELOAD;
            tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
          end else begin
            state_d = S_IDLE;
            baud_d  = 16'd0;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= WriteData[7:0];
  end

  assign count_ext = 7'(count_q);
  assign TxSerial  = tx_q;
  assign TxBusy    = (state_q != S_IDLE) || !fifo_empty;
  assign ReadData  = rd_status ?
                     {17'd0, count_ext, 4'd0, overrun_q, TxBusy, fifo_empty, fifo_full} :
                     32'd0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h1001_0040;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic        TxSerial;
  logic        TxBusy;

  uart_tx_mmio #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
    .TxSerial(TxSerial), .TxBusy(TxBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "which cycle of which frame" view.
  logic [7:0]       mq[$];
  bit               m_in_frame = 0;
  int               m_cyc = 0;
  bit               m_ovr = 0;
  logic [NBITS-1:0] m_frame = '0;
  bit               m_end, m_pop, m_req, m_acc, m_rd;

  function automatic logic [NBITS-1:0] make_frame(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f = '0;
    f[0] = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
    f[10] = 1'b1;
`else
    f[9] = 1'b1;
`endif
    return f;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_in_frame = 0;
      m_cyc = 0;
      m_ovr = 0;
    end else begin
      m_end = m_in_frame && (m_cyc == FRAME_CYC - 1);
      m_pop = (mq.size() > 0) && (!m_in_frame || m_end);
      m_req = MemWrite && (Address == BASE);
      m_acc = m_req && ((mq.size() < DEPTH) || m_pop);
      m_rd  = MemRead && (Address == BASE + 32'd4);
      if (m_pop) begin
        m_frame = make_frame(mq.pop_front());
        m_in_frame = 1;
        m_cyc = 0;
      end else if (m_end) begin
        m_in_frame = 0;
        m_cyc = 0;
      end else if (m_in_frame) begin
        m_cyc++;
      end
      if (m_acc) mq.push_back(WriteData[7:0]);
      if (m_req && !m_acc) m_ovr = 1;
      else if (m_rd) m_ovr = 0;
    end
  end

  function automatic logic exp_tx();
    return m_in_frame ? m_frame[m_cyc / DIV] : 1'b1;
  endfunction

  function automatic logic exp_busy();
    return m_in_frame || (mq.size() > 0);
  endfunction

  function automatic logic [31:0] exp_rdata();
    logic [6:0] c;
    c = 7'(mq.size());
    if (MemRead && (Address == BASE + 32'd4))
      return {17'd0, c, 4'd0, m_ovr, exp_busy(), mq.size() == 0, mq.size() == DEPTH};
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    check("tx_serial", 32'(TxSerial), 32'(exp_tx()));
    check("tx_busy", 32'(TxBusy), 32'(exp_busy()));
    check("read_data", ReadData, exp_rdata());
  end

  int busy_cycles = 0;
  always @(negedge clk) if (TxBusy) busy_cycles++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    Address = addr;
    WriteData = data;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    Address = '0;
    WriteData = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    Address = BASE + 32'd4;
    MemRead = 1'b1;
    #1 v = ReadData;
    tick();
    MemRead = 1'b0;
    Address = '0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (TxBusy && n < max) begin
      tick();
      n++;
    end
    check("drain_bound", 32'(TxBusy), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [NBITS-1:0] pat;
    logic [7:0] pat_byte;
    logic cap_tx [FRAME_CYC + 4];
    logic cap_busy [FRAME_CYC + 4];
    int lows;
    int guard;

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();

    // Reset state
    check("reset_tx", 32'(TxSerial), 32'd1);
    check("reset_busy", 32'(TxBusy), 32'd0);
    read_status(v);
    check("reset_status", v, 32'h0000_0002);

    // Single frame waveform, literal expectation
`ifdef UART_TX_PARITY_EN
    pat_byte = 8'h07;
    pat = 11'b11000001110;
`else
    pat_byte = 8'h55;
    pat = 10'b1010101010;
`endif
    store(BASE, {24'hFFFFFF, pat_byte});
    for (int k = 0; k < FRAME_CYC + 4; k++) begin
      @(negedge clk);
      cap_tx[k] = TxSerial;
      cap_busy[k] = TxBusy;
    end
    tick();
    for (int k = 0; k < FRAME_CYC + 4; k++) begin
      if (k >= 1 && k <= FRAME_CYC)
        check("frame_waveform", 32'(cap_tx[k]), 32'(pat[(k - 1) / DIV]));
      else
        check("frame_idle_high", 32'(cap_tx[k]), 32'd1);
    end
    check("busy_last_stop", 32'(cap_busy[FRAME_CYC]), 32'd1);
    check("busy_after_stop", 32'(cap_busy[FRAME_CYC + 1]), 32'd0);

    // Burst overrun, status clearing, push-on-pop when full
    wait_idle(200);
    busy_cycles = 0;
    for (int i = 0; i < 10; i++) store(BASE, $urandom);
    read_status(v);
    check("burst_status", v, 32'h0000_080D);
    read_status(v);
    check("status_after_clear", v, 32'h0000_0805);
    guard = 0;
    while (!(m_in_frame && m_cyc == FRAME_CYC - 1) && guard < 200) begin
      tick();
      guard++;
    end
    check("pop_edge_found", 32'(guard < 200), 32'd1);
    store(BASE, $urandom);
    read_status(v);
    check("push_on_pop_status", v, 32'h0000_0805);
    wait_idle(20 * FRAME_CYC);
    check("back_to_back_busy", 32'(busy_cycles), 32'(1 + 10 * FRAME_CYC));

    // Unmapped accesses
    Address = BASE + 32'd8;
    MemRead = 1'b1;
    #1 check("load_base_plus8", ReadData, 32'd0);
    Address = BASE;
    #1 check("load_data_reg", ReadData, 32'd0);
    tick();
    MemRead = 1'b0;
    store(BASE + 32'd4, 32'h41);
    tick();
    read_status(v);
    check("store_status_addr", v, 32'h0000_0002);

    // Reset during DATA bit 3
    store(BASE, 32'hA5);
    repeat (18) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("async_reset_tx", 32'(TxSerial), 32'd1);
    check("async_reset_busy", 32'(TxBusy), 32'd0);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    tick();
    read_status(v);
    check("post_reset_status", v, 32'h0000_0002);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!TxSerial) lows++;
    end
    tick();
    check("no_resumed_frame", 32'(lows), 32'd0);

    // First edge after reset accepts a push
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    Address = BASE;
    WriteData = 32'h3C;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
    Address = '0;
    read_status(v);
    check("first_push_after_reset", v, 32'h0000_0104);
    wait_idle(200);

    // Randomized traffic at several write rates
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 700; c++) begin
        int sel;
        MemWrite = ($urandom_range(0, 7) < p * 2 + 1);
        MemRead = ($urandom_range(0, 3) == 0);
        WriteData = $urandom;
        sel = $urandom_range(0, 99);
        if (sel < 55) Address = BASE;
        else if (sel < 85) Address = BASE + 32'd4;
        else if (sel < 93) Address = BASE + 32'd8;
        else Address = $urandom;
        tick();
      end
    end
    MemWrite = 1'b0;
    MemRead = 1'b0;
    Address = '0;
    wait_idle(20 * FRAME_CYC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 434, giving clock cycles per serial bit (115200 baud at 50 MHz); legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the transmit FIFO depth in bytes; power of two, 2..64.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h1001_0040, giving the byte address of the DATA register; STATUS is at BASE_ADDR+4.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port Address, input, 32 bits: the byte address from the processor MEM stage ALU result.
REQ-007 The block SHALL have port WriteData, input, 32 bits: the store data from the MEM stage.
REQ-008 The block SHALL have port MemWrite, input, 1 bit: the store strobe from the MEM stage.
REQ-009 The block SHALL have port MemRead, input, 1 bit: the load strobe from the MEM stage.
REQ-010 The block SHALL have port ReadData, output, 32 bits: the load data returned to the MEM/WB pipeline register.
REQ-011 The block SHALL have port TxSerial, output, 1 bit: the serial line, idle high.
REQ-012 The block SHALL have port TxBusy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.

Function
REQ-013 A write SHALL be decoded when MemWrite=1 and Address==BASE_ADDR; it pushes WriteData[7:0] into the FIFO on that rising edge; WriteData[31:8] are ignored.
REQ-014 A push SHALL be accepted when count<FIFO_DEPTH, or when a pop occurs on the same edge; otherwise the byte is dropped and sticky OVERRUN is set.
REQ-015 ReadData SHALL be combinational, zero latency: STATUS when MemRead=1 and Address==BASE_ADDR+4, otherwise 32'h0.
REQ-016 STATUS SHALL read: bit0 FULL, bit1 EMPTY, bit2 TxBusy, bit3 OVERRUN, bits[14:8] FIFO count, all other bits 0.
REQ-017 OVERRUN SHALL clear on the rising edge ending a STATUS read cycle, unless an overrun occurs on that same edge, in which case it stays set.
REQ-018 The transmitter FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with FIFO non-empty, the FSM SHALL pop the head byte into the shift register on the next edge and enter START.
REQ-020 Each of START, DATA-bit, PARITY and STOP SHALL hold TxSerial for exactly CLK_DIV cycles, timed by a baud counter reloaded at every bit boundary.
REQ-021 START SHALL drive 0; DATA SHALL drive 8 bits LSB first; STOP SHALL drive 1.
REQ-022 On leaving STOP, the FSM SHALL pop the next byte directly into START when the FIFO is non-empty (back-to-back frames, no idle gap), else enter IDLE.
REQ-023 TxSerial SHALL be a registered output, driven 1 in IDLE.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be held separately so that full and empty are unambiguous.

Reset
REQ-025 While reset=1, asynchronously: TxSerial=1, TxBusy=0, FSM=IDLE, FIFO empty with pointers and count 0, OVERRUN=0, baud counter 0.
REQ-026 A reset asserted mid-frame SHALL abort the frame immediately; no partial frame resumes after release.
REQ-027 The first push SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-028 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL be entered after bit 7 and drive even parity (XOR of the 8 data bits); frame = 11 bits.
REQ-029 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be compiled out and DATA SHALL go directly to STOP; frame = 10 bits.

Verification
REQ-030 CLK_DIV=4, no parity: store 32'hFFFF_FF55 to BASE_ADDR -> TxSerial = 0,1,0,1,0,1,0,1,0,1, each held for 4 cycles, then idle high; TxBusy falls after the stop bit.
REQ-031 CLK_DIV=4, UART_TX_PARITY_EN: store 8'h07 -> parity bit = 1; total frame 44 cycles.
REQ-032 FIFO_DEPTH=8: 10 back-to-back stores while line busy -> STATUS FULL=1, OVERRUN=1, count=8; next STATUS read -> OVERRUN=0; exactly 9 frames transmitted with no idle gap between them.
REQ-033 Push on the same edge the FSM pops from a full FIFO -> push accepted, count stays 8, OVERRUN stays 0.
REQ-034 Assert reset for 1 cycle during DATA bit 3 -> TxSerial=1 asynchronously, STATUS afterwards = 32'h0000_0002, no further frame output.
REQ-035 Load from BASE_ADDR+8 or store to BASE_ADDR+4 -> ReadData=0, FIFO unchanged.
